pattern_scan_ctrl: RTL and testbench
====================================

// Module: pattern_scan_ctrl
// PURPOSE
//  Sequencer/arbiter that shares one serial 1101 Mealy detector among NUM_REQ requesters.
//  Grants one requester round-robin, latches its parallel word and clears the detector.
//  Shifts the word MSB-first into the detector and counts detector hits.
//  Returns the count through a valid/ready result handshake.
// PARAMETERS
//  NUM_REQ    2  number of requesters (>=2)
//  WORD_BITS  8  bits per word scanned (>=4)
//  COUNT_W    $clog2(WORD_BITS+1)  result count width (derived, localparam)
// PORTS
//  clk           in   1                  system clock, all logic on rising edge
//  n_rst         in   1                  reset, synchronous, active-low
//  req           in   NUM_REQ            per-requester scan request (level)
//  req_data      in   NUM_REQ*WORD_BITS  packed words; requester k at [k*WORD_BITS +: WORD_BITS]
//  ack           out  NUM_REQ            one-cycle onehot pulse: word k latched
//  det_n_rst     out  1                  detector synchronous active-low clear (registered)
//  det_i         out  1                  serial bit to detector (registered)
//  det_o         in   1                  detector Mealy output, valid same cycle as det_i
//  result_valid  out  1                  result held valid
//  result_ready  in   1                  consumer accepts result
//  result_id     out  $clog2(NUM_REQ)    granted requester index
//  result_count  out  COUNT_W            detector hits in word (first-hit mode: see CONFIG)
// BEHAVIOUR
//  Reset (n_rst=0 at edge): state=IDLE, ack=0, det_n_rst=0, det_i=1 (line idle-high),
//   result_valid=0, result_id=0, result_count=0, rr_ptr=0. Reset mid-operation aborts the scan; no result.
//  FSM: IDLE -> CLEAR -> SHIFT -> REPORT -> IDLE.
//  IDLE: det_n_rst=1, det_i=1. If any req: grant first set req[k] searching k=rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   Latch word k, pulse ack[k], set rr_ptr=k+1 mod NUM_REQ, clear hit count, go CLEAR.
//  CLEAR: det_n_rst=0 for exactly one cycle, det_i=1; bit_cnt=0; go SHIFT.
//  SHIFT: det_n_rst=1, det_i=word[WORD_BITS-1-bit_cnt].
//   Each cycle det_o=1 increments count (saturating at 2^COUNT_W-1).
//   After WORD_BITS cycles, go REPORT.
//  REPORT: result_valid=1, id/count stable until the cycle result_ready=1; then next cycle IDLE, valid=0.
//   det_i=1. Requests are not sampled in REPORT; req asserted meanwhile waits, never lost (level).
//  Latency: ack at cycle 0; det_n_rst low cycle 1; bits on cycles 2..WORD_BITS+1; result_valid from WORD_BITS+2.
//  Simultaneous requests: only one ack per grant; the other requester is granted on the next IDLE pass.
//  A requester holds req/req_data until its ack; req dropped before ack = no scan.
//  result_ready high in IDLE/CLEAR/SHIFT is ignored.
// CONFIGURATION
//  SCAN_FIRST_HIT_EN defined: SHIFT ends on the first det_o=1 and goes directly to REPORT.
//   result_count = bit position+1 of first hit (1..WORD_BITS), 0 if no hit after WORD_BITS bits.
//  Undefined: full word always shifted; result_count = total hit count.
// TESTING (NUM_REQ=2, WORD_BITS=8, macro undefined unless noted)
//  n_rst=0 for 2 edges with req=2'b11 -> ack=0, det_n_rst=0, det_i=1, result_valid=0.
//  req[0], word 8'hD0 (1101_0000) -> ack=01 at cycle 0, result_valid at cycle 10, id=0, count=1.
//  req[1], word 8'hDA (1101_1010) -> overlapping hits at bits 3 and 6 -> id=1, count=2; 8'hAA -> count=0.
//  req=2'b11 after reset, result_ready low 3 cycles -> id=0 held stable 3 cycles, then id=1 scan; rr alternates.
//  n_rst=0 during 4th SHIFT cycle -> next edge IDLE, det_n_rst=0, result_valid never asserted for that word.
//  SCAN_FIRST_HIT_EN, word 8'hDA -> REPORT after 4 SHIFT cycles, count=4; 8'h00 -> count=0 after 8.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - round-robin sequencer sharing one serial 1101 detector among requesters.
// Optional SCAN_FIRST_HIT_EN: stop on the first detector hit and report its bit position.
module pattern_scan_ctrl #(
  parameter int  NUM_REQ   = 2,
  parameter int  WORD_BITS = 8,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int COUNT_W   = $clog2(WORD_BITS + 1)
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WORD_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           det_n_rst,
  output logic                           det_i,
  input  logic                           det_o,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [ID_W-1:0]                result_id,
  output logic [COUNT_W-1:0]             result_count
);

  localparam int BIT_W = $clog2(WORD_BITS);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

  state_t               state, state_n;
  logic [ID_W-1:0]      rr_ptr, rr_ptr_n;
  logic [WORD_BITS-1:0] word, word_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 det_n_rst_n, det_i_n, result_valid_n;
  logic [ID_W-1:0]      result_id_n;
  logic [COUNT_W-1:0]   result_count_n;
`ifndef SCAN_FIRST_HIT_EN
  logic [COUNT_W-1:0]   hit_cnt, hit_cnt_n, hit_inc;
`endif

  logic            found;
  logic [ID_W-1:0] gnt_id;
  int              idx;

  // Search starts at rr_ptr and wraps, so the last-served requester goes to the back.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  // ack is combinational so it lands in the same cycle the word is captured.
  assign ack = (n_rst && (state == IDLE) && found) ? (NUM_REQ'(1) << gnt_id) : '0;

`ifndef SCAN_FIRST_HIT_EN
  assign hit_inc = (det_o && (hit_cnt != '1)) ? hit_cnt + COUNT_W'(1) : hit_cnt;
`endif

  // Registered outputs are computed from the state being entered, so each state
  // label matches what is currently on the detector lines.
  always_comb begin
    state_n        = state;
    rr_ptr_n       = rr_ptr;
    word_n         = word;
    bit_cnt_n      = bit_cnt;
    det_n_rst_n    = 1'b1;
    det_i_n        = 1'b1;
    result_valid_n = result_valid;
    result_id_n    = result_id;
    result_count_n = result_count;
`ifndef SCAN_FIRST_HIT_EN
    hit_cnt_n      = hit_cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          word_n      = req_data[int'(gnt_id)*WORD_BITS +: WORD_BITS];
          rr_ptr_n    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
          result_id_n = gnt_id;
`ifndef SCAN_FIRST_HIT_EN
          hit_cnt_n   = '0;
`endif
          det_n_rst_n = 1'b0;
          state_n     = CLEAR;
        end
      end
      CLEAR: begin
        det_i_n   = word[WORD_BITS-1];
        word_n    = {word[WORD_BITS-2:0], 1'b0};
        bit_cnt_n = '0;
        state_n   = SHIFT;
      end
      SHIFT: begin
`ifdef SCAN_FIRST_HIT_EN
        if (det_o) begin
          result_count_n = COUNT_W'(bit_cnt) + COUNT_W'(1);
          result_valid_n = 1'b1;
          state_n        = REPORT;
        end else if (bit_cnt == BIT_W'(WORD_BITS - 1)) begin
          result_count_n = '0;
          result_valid_n = 1'b1;
          state_n        = REPORT;
        end
`else
        hit_cnt_n = hit_inc;
        if (bit_cnt == BIT_W'(WORD_BITS - 1)) begin
          result_count_n = hit_inc;
          result_valid_n = 1'b1;
          state_n        = REPORT;
        end
`endif
        if (state_n == SHIFT) begin
          det_i_n   = word[WORD_BITS-1];
          word_n    = {word[WORD_BITS-2:0], 1'b0};
          bit_cnt_n = bit_cnt + BIT_W'(1);
        end
      end
      REPORT: begin
        if (result_ready) begin
          result_valid_n = 1'b0;
          state_n        = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      word         <= '0;
      bit_cnt      <= '0;
      det_n_rst    <= 1'b0;
      det_i        <= 1'b1;
      result_valid <= 1'b0;
      result_id    <= '0;
      result_count <= '0;
`ifndef SCAN_FIRST_HIT_EN
      hit_cnt      <= '0;
`endif
    end else begin
      state        <= state_n;
      rr_ptr       <= rr_ptr_n;
      word         <= word_n;
      bit_cnt      <= bit_cnt_n;
      det_n_rst    <= det_n_rst_n;
      det_i        <= det_i_n;
      result_valid <= result_valid_n;
      result_id    <= result_id_n;
      result_count <= result_count_n;
`ifndef SCAN_FIRST_HIT_EN
      hit_cnt      <= hit_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - scoreboard bench for pattern_scan_ctrl with a behavioural 1101 detector.
module tb_pattern_scan_ctrl;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic        det_n_rst, det_i, det_o;
  logic        result_valid, result_ready;
  logic [0:0]  result_id;
  logic [3:0]  result_count;

  int total = 0;
  int bad   = 0;
  int sb[$];

  always #5 tb_clk = ~tb_clk;

  pattern_scan_ctrl #(.NUM_REQ(2), .WORD_BITS(8)) dut (
    .clk(tb_clk), .n_rst(n_rst), .req(req), .req_data(req_data), .ack(ack),
    .det_n_rst(det_n_rst), .det_i(det_i), .det_o(det_o),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_count(result_count)
  );

  // Overlapping 1101 Mealy detector: states 0 none, 1 "1", 2 "11", 3 "110".
  function automatic logic [1:0] det_next(input logic [1:0] s, input logic x);
    case (s)
      2'd0:    det_next = x ? 2'd1 : 2'd0;
      2'd1:    det_next = x ? 2'd2 : 2'd0;
      2'd2:    det_next = x ? 2'd2 : 2'd3;
      default: det_next = x ? 2'd1 : 2'd0;
    endcase
  endfunction

  logic [1:0] dst;
  always @(posedge tb_clk) begin
    if (!det_n_rst) dst <= 2'd0;
    else            dst <= det_next(dst, det_i);
  end
  assign det_o = (dst == 2'd3) && det_i;

  function automatic int first_hit(input logic [7:0] w);
    logic [1:0] s = 2'd0;
    int f = 0;
    for (int b = 7; b >= 0; b--) begin
      if (s == 2'd3 && w[b] && f == 0) f = 8 - b;
      s = det_next(s, w[b]);
    end
    return f;
  endfunction

  function automatic int hit_total(input logic [7:0] w);
    logic [1:0] s = 2'd0;
    int c = 0;
    for (int b = 7; b >= 0; b--) begin
      if (s == 2'd3 && w[b]) c++;
      s = det_next(s, w[b]);
    end
    return c;
  endfunction

  function automatic int exp_count(input logic [7:0] w);
`ifdef SCAN_FIRST_HIT_EN
    return first_hit(w);
`else
    return hit_total(w);
`endif
  endfunction

  function automatic int exp_bits(input logic [7:0] w);
`ifdef SCAN_FIRST_HIT_EN
    return (first_hit(w) == 0) ? 8 : first_hit(w);
`else
    return 8;
`endif
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Accepted results are compared against the oldest pending expectation.
  always @(negedge tb_clk) begin
    if (n_rst && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        int e;
        e = sb.pop_front();
        check("result_id", int'(result_id), e / 256);
        check("result_count", int'(result_count), e % 256);
      end
    end
  end

  task automatic scan(input int k, input logic [7:0] w, input logic [1:0] exp_ack);
    int cyc;
    bit seen;
    req_data[k*8 +: 8] = w;
    req[k] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge tb_clk);
      if (ack != 2'b00) seen = 1'b1;
    end
    if (!seen) begin
      check("ack_timeout", 0, 1);
      req[k] = 1'b0;
      return;
    end
    check("ack", int'(ack), int'(exp_ack));
    sb.push_back(k * 256 + exp_count(w));
    @(posedge tb_clk);
    #1 req[k] = 1'b0;
    @(negedge tb_clk);
    check("det_clear", int'(det_n_rst), 0);
    check("ack_pulse", int'(ack), 0);
    @(negedge tb_clk);
    check("det_release", int'(det_n_rst), 1);
    check("first_bit", int'(det_i), int'(w[7]));
    cyc = 2;
    while (!result_valid && cyc < 40) begin
      @(negedge tb_clk);
      cyc++;
    end
    check("latency", cyc, 2 + exp_bits(w));
  endtask

  initial begin
    int vcount;
    n_rst = 1'b0;
    req = 2'b11;
    req_data = '0;
    result_ready = 1'b1;
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    check("rst_ack", int'(ack), 0);
    check("rst_det_n_rst", int'(det_n_rst), 0);
    check("rst_det_i", int'(det_i), 1);
    check("rst_valid", int'(result_valid), 0);
    req = 2'b00;
    n_rst = 1'b1;
    @(posedge tb_clk);
    #1;

    scan(0, 8'hD0, 2'b01);
    scan(1, 8'hDA, 2'b10);
    scan(1, 8'hAA, 2'b10);
    scan(0, 8'h00, 2'b01);

    // Fresh reset, both requesting, consumer stalls the first result.
    @(posedge tb_clk);
    #1 n_rst = 1'b0;
    req_data = {8'hDA, 8'hD0};
    req = 2'b11;
    @(posedge tb_clk);
    #1 n_rst = 1'b1;
    result_ready = 1'b0;
    scan(0, 8'hD0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", int'(result_valid), 1);
      check("hold_id", int'(result_id), 0);
      check("hold_ack", int'(ack), 0);
      @(posedge tb_clk);
      #1;
      @(negedge tb_clk);
    end
    result_ready = 1'b1;
    scan(1, 8'hDA, 2'b10);
    req = 2'b11;
    scan(0, 8'hDA, 2'b01);
    scan(1, 8'hD0, 2'b10);

    // Reset during the fourth SHIFT cycle aborts the scan.
    @(posedge tb_clk);
    #1 req_data[7:0] = 8'hD0;
    req[0] = 1'b1;
    vcount = 0;
    for (int i = 0; i < 30 && ack == 2'b00; i++) @(negedge tb_clk);
    check("abort_ack", int'(ack), 1);
    @(posedge tb_clk);
    #1 req[0] = 1'b0;
    repeat (4) @(posedge tb_clk);
    #1 n_rst = 1'b0;
    @(posedge tb_clk);
    @(negedge tb_clk);
    check("abort_det_n_rst", int'(det_n_rst), 0);
    check("abort_det_i", int'(det_i), 1);
    check("abort_valid_now", int'(result_valid), 0);
    @(posedge tb_clk);
    #1 n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge tb_clk);
      if (result_valid) vcount++;
    end
    check("abort_no_result", vcount, 0);

    check("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
